packet_stream_buffer: RTL



---
 rtl/packet_stream_buffer.sv | 93 +++++++++
 1 files changed

// File: rtl/packet_stream_buffer.sv
// packet_stream_buffer: small FIFO behind the packet stage. Input packets are
// qualified by their own valid bit; overflowing packets are dropped and counted
// in a saturating counter. The output packet's valid bit means "head present".
module packet_stream_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [10:0]              in_pkt,
    output logic                     in_ready,
    output logic [10:0]              out_pkt,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         drop_cnt,
    input  logic                     drop_clr
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

    // Entries hold {payload, channel}; valid is implied by occupancy.
    logic [9:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          empty;
    logic          in_valid;
    logic          push;
    logic          drop;
    logic          pop;

    // Handshake decisions, all based on the occupancy before the edge
    always_comb begin
        full     = (level == LVL_FULL);
        empty    = (level == '0);
        in_valid = in_pkt[2];
        push     = in_valid & ~full;
        drop     = in_valid & full;
        pop      = ~empty & out_ready;
    end

    assign in_ready = ~full;

    // Storage write; contents are not reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_pkt[10:3], in_pkt[1:0]};
        end
    end

    // Pointer and occupancy tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

    // Saturating drop counter; a clear coinciding with a drop leaves a count of one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (drop_clr) begin
            drop_cnt <= drop ? CNT_W'(1) : '0;
        end else if (drop && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + CNT_W'(1);
        end
    end

    // Head entry presented with valid set; all-zero when empty
    always_comb begin
        out_pkt = '0;
        if (!empty) begin
            out_pkt = {mem[rd_ptr][9:2], 1'b1, mem[rd_ptr][1:0]};
        end
    end

endmodule
